seq_detect_arbiter: RTL and testbench

Shares one serial pattern-detector datapath among NCH serial requesters. A round-robin arbiter grants one channel at a time and streams exactly FRAME_LEN valid bits from that channel through an embedded Moore-style overlapping pattern matcher. At frame end it reports the channel index, the match count and an abort flag. It sits between the per-lane serial front ends and the status/collection logic.

---
 rtl/seq_detect_arbiter.sv | 154 +++++++++++++++
 tb/tb_seq_detect_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter that lends one overlapping serial pattern matcher to NCH
// requesters, one fixed-length frame at a time, and reports per-frame results.
module seq_detect_arbiter #(
  parameter int                 NCH       = 4,
  parameter int                 FRAME_LEN = 8,
  parameter int                 PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1010
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NCH-1:0]                 req,
  input  logic [NCH-1:0]                 bit_in,
  input  logic [NCH-1:0]                 bit_vld,
  output logic [NCH-1:0]                 gnt,
  output logic                           busy,
  output logic                           match,
  output logic                           done,
  output logic                           aborted,
  output logic [$clog2(NCH)-1:0]         done_ch,
  output logic [$clog2(FRAME_LEN+1)-1:0] match_cnt
);

  localparam int CW = $clog2(NCH);
  localparam int MW = $clog2(FRAME_LEN+1);

  typedef enum logic [1:0] {IDLE, STREAM, REPORT} state_t;

  state_t             state_q, state_d;
  logic [NCH-1:0]     gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic [CW-1:0]      done_ch_q, done_ch_d;
  logic [MW-1:0]      match_cnt_q, match_cnt_d;
  logic [CW-1:0]      ptr_q, ptr_d;
  logic [PAT_LEN-1:0] sh_q, sh_d;
  logic [MW-1:0]      cnt_q, cnt_d;

  logic [CW-1:0]      sel;
  logic [PAT_LEN-1:0] sh_nxt;
  logic [MW-1:0]      cnt_inc;

  // Scanning downward lets the lowest offset from the pointer win without a break.
  function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] r, input logic [CW-1:0] p);
    logic [CW-1:0] pick;
    logic [CW-1:0] idx;
    pick = p;
    for (int i = NCH-1; i >= 0; i--) begin
      idx = CW'((int'(p) + i) % NCH);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign sel     = rr_pick(req, ptr_q);
  assign sh_nxt  = {sh_q[PAT_LEN-2:0], bit_in[done_ch_q]};
  assign cnt_inc = cnt_q + MW'(1);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    match_d     = 1'b0;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    done_ch_d   = done_ch_q;
    match_cnt_d = match_cnt_q;
    ptr_d       = ptr_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = STREAM;
          gnt_d        = '0;
          gnt_d[sel]   = 1'b1;
          busy_d       = 1'b1;
          aborted_d    = 1'b0;
          done_ch_d    = sel;
          match_cnt_d  = '0;
          sh_d         = '0;
          cnt_d        = '0;
        end
      end
      STREAM: begin
        // A dropped request wins over a simultaneous bit qualifier.
        if (!req[done_ch_q]) begin
          state_d   = REPORT;
          gnt_d     = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (bit_vld[done_ch_q]) begin
          sh_d  = sh_nxt;
          cnt_d = cnt_inc;
          if (sh_nxt == PATTERN && cnt_inc >= MW'(PAT_LEN)) begin
            match_d     = 1'b1;
            match_cnt_d = match_cnt_q + MW'(1);
          end
          if (cnt_inc == MW'(FRAME_LEN)) begin
            state_d   = REPORT;
            gnt_d     = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = 1'b0;
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
        ptr_d   = (done_ch_q == CW'(NCH-1)) ? '0 : done_ch_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      done_ch_q   <= '0;
      match_cnt_q <= '0;
      ptr_q       <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      match_q     <= match_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      done_ch_q   <= done_ch_d;
      match_cnt_q <= match_cnt_d;
      ptr_q       <= ptr_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign match     = match_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign done_ch   = done_ch_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scoreboard bench for seq_detect_arbiter: a driver queues expected grants and
// frame reports, a negedge monitor pops and compares them as the DUT emits them.
module tb_seq_detect_arbiter;

  localparam int                 NCH       = 4;
  localparam int                 FRAME_LEN = 8;
  localparam int                 PAT_LEN   = 4;
  localparam logic [PAT_LEN-1:0] PATTERN   = 4'b1010;
  localparam int                 CW        = $clog2(NCH);
  localparam int                 MW        = $clog2(FRAME_LEN+1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] bit_in = '0;
  logic [NCH-1:0] bit_vld = '0;
  logic [NCH-1:0] gnt;
  logic           busy, match, done, aborted;
  logic [CW-1:0]  done_ch;
  logic [MW-1:0]  match_cnt;

  always #5 clk = ~clk;

  seq_detect_arbiter #(
    .NCH(NCH), .FRAME_LEN(FRAME_LEN), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .bit_vld(bit_vld),
    .gnt(gnt), .busy(busy), .match(match), .done(done), .aborted(aborted),
    .done_ch(done_ch), .match_cnt(match_cnt)
  );

  typedef struct {
    int ch;
    int cnt;
    bit ab;
    bit last;
  } exp_t;

  exp_t           fq[$];
  int             gq[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             ptr_m = 0;
  bit             in_frame = 0;
  bit             have_prev = 0;
  int             pulses = 0;
  int             low_cnt = 0;
  logic [NCH-1:0] prev_gnt = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_model(input logic [NCH-1:0] m, input int p);
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (p + i) % NCH;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  // Count every PAT_LEN-bit window (oldest bit first) of the first n bits that equals PATTERN.
  function automatic void frame_model(input logic [FRAME_LEN-1:0] f, input int n,
                                      output int cnt, output bit last);
    logic [PAT_LEN-1:0] w;
    cnt  = 0;
    last = 1'b0;
    for (int i = PAT_LEN-1; i < n; i++) begin
      for (int j = 0; j < PAT_LEN; j++)
        w[PAT_LEN-1-j] = f[FRAME_LEN-1-(i-PAT_LEN+1+j)];
      if (w == PATTERN) begin
        cnt++;
        if (i == FRAME_LEN-1) last = 1'b1;
      end
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (!rst) begin
      prev_gnt = '0;
    end else begin
      chk("gnt_onehot0", int'($onehot0(gnt)), 1);
      if (gnt != '0 && prev_gnt == '0) begin
        if (gq.size() == 0) chk("unexpected_grant", int'(gnt), 0);
        else begin
          g = gq.pop_front();
          chk("grant", int'(gnt), 1 << g);
        end
        if (have_prev) chk("gnt_gap_ge2", int'(low_cnt >= 2), 1);
        in_frame = 1'b1;
        pulses   = 0;
      end
      if (match) pulses++;
      if (done) begin
        in_frame  = 1'b0;
        have_prev = 1'b1;
        low_cnt   = 0;
        if (fq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = fq.pop_front();
          chk("done_ch", int'(done_ch), e.ch);
          chk("match_cnt", int'(match_cnt), e.cnt);
          chk("aborted", int'(aborted), int'(e.ab));
          chk("match_pulses", pulses, e.cnt);
          chk("match_with_done", int'(match), int'(e.last));
          chk("gnt_at_done", int'(gnt), 0);
        end
      end
      chk("busy", int'(busy), int'(in_frame));
      if (gnt == '0) low_cnt++;
      else low_cnt = 0;
      prev_gnt = gnt;
    end
  end

  task automatic drive_noise(input int g, input logic v, input logic b);
    bit_vld    = NCH'($urandom);
    bit_in     = NCH'($urandom);
    bit_vld[g] = v;
    bit_in[g]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_done_ch", int'(done_ch), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    req     = '0;
    bit_vld = '0;
    bit_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_done", int'(done), 0);
    chk("rst_hold_gnt", int'(gnt), 0);
    fq.delete();
    gq.delete();
    ptr_m     = 0;
    in_frame  = 1'b0;
    have_prev = 1'b0;
    pulses    = 0;
    low_cnt   = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // stop_k >= 0: feed only stop_k bits, then either reset (do_rst) or drop req.
  task automatic run_frame(input logic [NCH-1:0] mask, input logic [FRAME_LEN-1:0] f,
                           input int gap_at, input int gap_len, input int stop_k,
                           input bit do_rst, input bit hold, input bit rnd_gap);
    int   g, wt, n, cnt, gl;
    bit   last;
    exp_t e;
    g = rr_model(mask, ptr_m);
    gq.push_back(g);
    req = mask;
    wt  = 0;
    while (gnt == '0 && wt < 30) begin
      @(posedge clk);
      #1;
      wt++;
    end
    if (gnt == '0) begin
      chk("grant_timeout", 0, 1);
      void'(gq.pop_back());
      req = '0;
      return;
    end
    n = (stop_k >= 0) ? stop_k : FRAME_LEN;
    if (!do_rst) begin
      frame_model(f, n, cnt, last);
      e.ch   = g;
      e.cnt  = cnt;
      e.ab   = (stop_k >= 0);
      e.last = last && (stop_k < 0);
      fq.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      gl = rnd_gap ? int'($urandom_range(0, 2)) : ((i == gap_at) ? gap_len : 0);
      repeat (gl) begin
        drive_noise(g, 1'b0, 1'b0);
        @(posedge clk);
        #1;
      end
      drive_noise(g, 1'b1, f[FRAME_LEN-1-i]);
      @(posedge clk);
      #1;
    end
    if (do_rst) begin
      do_reset();
      return;
    end
    if (stop_k >= 0) begin
      req = mask & ~(NCH'(1) << g);
      drive_noise(g, 1'b1, 1'($urandom));
      @(posedge clk);
      #1;
    end
    ptr_m   = (g + 1) % NCH;
    bit_vld = '0;
    if (!hold) req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NCH-1:0]       m;
    logic [FRAME_LEN-1:0] f;
    int                   stop;
    #1;
    do_reset();
    // Basic detection and frame reporting
    run_frame(4'b0001, 8'b10101010, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0100, 8'b11010100, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0100, 8'b00100000, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    // Round-robin with request held across frames
    do_reset();
    for (int k = 0; k < 4; k++)
      run_frame(4'b1010, FRAME_LEN'($urandom), -1, 0, -1, 1'b0, (k < 3), 1'b0);
    // Stall between bits 2 and 3
    run_frame(4'b0001, 8'b10101010, 2, 3, -1, 1'b0, 1'b0, 1'b0);
    // Abort after five bits, then pointer moves past the aborted channel
    run_frame(4'b0010, 8'b10101000, -1, 0, 5, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0111, FRAME_LEN'($urandom), -1, 0, -1, 1'b0, 1'b0, 1'b0);
    // Reset mid-frame, then channel 0 first
    run_frame(4'b1111, FRAME_LEN'($urandom), -1, 0, 3, 1'b1, 1'b0, 1'b0);
    run_frame(4'b1111, FRAME_LEN'($urandom), -1, 0, -1, 1'b0, 1'b0, 1'b0);
    // Randomized frames
    for (int k = 0; k < 24; k++) begin
      m    = NCH'($urandom_range(1, (1 << NCH) - 1));
      f    = FRAME_LEN'($urandom);
      stop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME_LEN-1)) : -1;
      run_frame(m, f, -1, 0, stop, 1'b0, 1'b0, 1'b1);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("frames_outstanding", fq.size(), 0);
    chk("grants_outstanding", gq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
